cache_refill_unit: RTL and testbench
====================================

# cache_refill_unit

Line refill engine sitting directly downstream of the set-associative cache controller. It accepts one miss at a time: the line address, the chosen victim way, and optionally a dirty victim line. It writes the victim back to main memory, fetches the missing 128-bit line as a burst of 32-bit beats, and assembles the line. It then hands the line and way back to the controller for installation into that way's data and tag stores.

## Interface
Parameters:
- NUM_WAYS, 8, associativity of the cache; WAY_W = $clog2(NUM_WAYS)
- ADDR_W, 32, byte address width
- LINE_W, 128, cache line width in bits
- BEAT_W, 32, memory bus data width; BEATS = LINE_W/BEAT_W (4); LINE_W must be an integer multiple of BEAT_W

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- miss_valid  in  1  miss request present
- miss_ready  out  1  unit can accept a miss
- miss_addr  in  ADDR_W  missing line address; low $clog2(LINE_W/8) bits ignored
- miss_way  in  WAY_W  victim way to refill
- miss_wb  in  1  victim is dirty and must be written back
- miss_wb_addr  in  ADDR_W  victim line address
- miss_wb_data  in  LINE_W  victim line data
- mem_req_valid  out  1  burst request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = write burst, 0 = read burst
- mem_req_addr  out  ADDR_W  line-aligned burst address
- mem_wdata  out  BEAT_W  write beat
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  memory accepts write beat
- mem_rdata  in  BEAT_W  read beat
- mem_rvalid  in  1  read beat valid; no backpressure
- fill_valid  out  1  assembled line ready for controller
- fill_ready  in  1  controller accepts fill
- fill_addr  out  ADDR_W  line-aligned address of filled line
- fill_way  out  WAY_W  way to install into
- fill_data  out  LINE_W  assembled line
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL.
- IDLE: miss_ready=1. On miss_valid, capture the address (line-aligned), way, wb flag, wb address and wb data.
  - If the captured wb flag is set, go to WB_REQ.
  - Otherwise go to RD_REQ.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_req_addr = aligned wb address. On mem_req_ready, go to WB_DATA with beat counter = 0.
- WB_DATA: mem_wvalid=1, mem_wdata = captured wb data beat[cnt]. Beat k is bits [k*BEAT_W +: BEAT_W]. cnt increments on each mem_wready. On acceptance of beat BEATS-1, go to RD_REQ.
- RD_REQ: mem_req_valid=1, mem_req_write=0, mem_req_addr = aligned miss address. On mem_req_ready, go to RD_DATA with cnt = 0.
- RD_DATA: each mem_rvalid writes mem_rdata into line beat[cnt] and increments cnt. On beat BEATS-1, go to FILL.
- FILL: fill_valid=1 and fill outputs stable. On fill_ready, go to IDLE.
- Request outputs are held stable while valid is high and ready is low.
- mem_rvalid outside RD_DATA is ignored. mem_wready outside WB_DATA is ignored.
- cnt is $clog2(BEATS) bits and is cleared on entry to each data phase; it never wraps mid-phase.
- Reset at any time forces IDLE and discards any partial line or pending writeback; no memory traffic is issued afterwards.

## Timing
- Reset values: miss_ready=0 during reset, 1 the first cycle after deassertion. All other control outputs are 0. mem_req_addr, mem_wdata, fill_addr, fill_way and fill_data are 0.
- Miss accepted at cycle 0, no writeback, memory always ready:
  - mem_req_valid at cycle 1
  - read beats at cycles 2–5
  - fill_valid at cycle 6
  - miss_ready at cycle 7 if fill_ready is high at cycle 6
- A writeback adds 1 request cycle plus BEATS write cycles (minimum 5 cycles).
- No new miss is accepted while busy. miss_ready and fill_valid are never high in the same cycle.

## Configuration
- REFILL_WRITEBACK_EN defined: behaviour as above (write-back cache).
- Undefined:
  - miss_wb, miss_wb_addr and miss_wb_data are ignored.
  - WB_REQ and WB_DATA are unreachable and synthesised out.
  - mem_req_write and mem_wvalid are tied 0 (write-through cache; stores go elsewhere).

## Test plan
- Clean miss: miss_addr=0x0000_1234, way=3, wb=0. Memory returns beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 → mem_req_addr=0x0000_1230 with write=0. Then fill_addr=0x0000_1230, fill_way=3, fill_data=0x44444444_33333333_22222222_11111111 at cycle 6.
- Dirty miss (EN defined): wb_addr=0x0000_8000, wb_data=0xDDDD…_AAAA… → write burst to 0x0000_8000 with beats emitted low word first. Read request to the miss address only after beat 3 is accepted.
- Backpressure: mem_req_ready low for 3 cycles, mem_wready toggling, fill_ready low for 2 cycles → request address and data are held stable and no beat is skipped or duplicated. miss_ready stays 0 until the fill handshake completes.
- Gapped and stray reads: mem_rvalid pulsed in IDLE and RD_REQ, then 4 beats with 1-cycle gaps in RD_DATA → stray beats are ignored and the line assembles correctly.
- Reset during the second read beat → next cycle all outputs are at reset values and busy=0. A subsequent clean miss completes with the correct data.
- EN undefined, miss_wb=1 → no write burst (mem_req_write never 1); the read burst is issued directly.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Line refill engine: optional dirty-victim writeback burst, then a read burst that
// assembles one cache line for the controller. Writeback path enabled by REFILL_WRITEBACK_EN.
module cache_refill_unit #(
  parameter int NUM_WAYS = 8,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int BEAT_W   = 32,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [WAY_W-1:0]  miss_way,
  input  logic              miss_wb,
  input  logic [ADDR_W-1:0] miss_wb_addr,
  input  logic [LINE_W-1:0] miss_wb_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [WAY_W-1:0]  fill_way,
  output logic [LINE_W-1:0] fill_data,
  output logic              busy
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_DATA,
    S_RD_REQ,
    S_RD_DATA,
    S_FILL
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BEATS-1:0]    beat_we;
  logic                cnt_last;

`ifdef REFILL_WRITEBACK_EN
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]   wb_data_q, wb_data_d;
  logic [BEAT_W-1:0]   wb_beat [BEATS];
`else
  logic                unused_wb_inputs;
  assign unused_wb_inputs = ^{miss_wb, miss_wb_addr, miss_wb_data, mem_wready};
`endif

  assign cnt_last = (cnt_q == CNT_LAST);

  // Each beat slot of the line buffer loads only while its index is the current count.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    assign beat_we[gi] = (state_q == S_RD_DATA) && mem_rvalid && (cnt_q == CNT_W'(gi));
    assign line_d[gi*BEAT_W +: BEAT_W] = beat_we[gi] ? mem_rdata : line_q[gi*BEAT_W +: BEAT_W];
`ifdef REFILL_WRITEBACK_EN
    assign wb_beat[gi] = wb_data_q[gi*BEAT_W +: BEAT_W];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
`ifdef REFILL_WRITEBACK_EN
          state_d = miss_wb ? S_WB_REQ : S_RD_REQ;
`else
          state_d = S_RD_REQ;
`endif
        end
      end
`ifdef REFILL_WRITEBACK_EN
      S_WB_REQ:  if (mem_req_ready) state_d = S_WB_DATA;
      S_WB_DATA: if (mem_wready && cnt_last) state_d = S_RD_REQ;
`endif
      S_RD_REQ:  if (mem_req_ready) state_d = S_RD_DATA;
      S_RD_DATA: if (mem_rvalid && cnt_last) state_d = S_FILL;
      S_FILL:    if (fill_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ready    = (state_q == S_IDLE) && !rst;
    busy          = (state_q != S_IDLE);
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    fill_valid    = 1'b0;
    case (state_q)
`ifdef REFILL_WRITEBACK_EN
      S_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = wb_addr_q;
      end
      S_WB_DATA: begin
        mem_wvalid = 1'b1;
        mem_wdata  = wb_beat[cnt_q];
      end
`endif
      S_RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
      end
      S_FILL:  fill_valid = 1'b1;
      default: ;
    endcase
  end

  assign fill_addr = addr_q;
  assign fill_way  = way_q;
  assign fill_data = line_q;

  always_comb begin
    addr_d = addr_q;
    way_d  = way_q;
    cnt_d  = cnt_q;
`ifdef REFILL_WRITEBACK_EN
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          addr_d = miss_addr & ALIGN_MASK;
          way_d  = miss_way;
`ifdef REFILL_WRITEBACK_EN
          wb_addr_d = miss_wb_addr & ALIGN_MASK;
          wb_data_d = miss_wb_data;
`endif
        end
      end
`ifdef REFILL_WRITEBACK_EN
      S_WB_REQ:  if (mem_req_ready) cnt_d = '0;
      S_WB_DATA: if (mem_wready) cnt_d = cnt_q + CNT_W'(1);
`endif
      S_RD_REQ:  if (mem_req_ready) cnt_d = '0;
      S_RD_DATA: if (mem_rvalid) cnt_d = cnt_q + CNT_W'(1);
      default: ;
    endcase
  end

  // A reset mid-burst drops the partial line and any pending victim data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      way_q  <= '0;
      cnt_q  <= '0;
      line_q <= '0;
`ifdef REFILL_WRITEBACK_EN
      wb_addr_q <= '0;
      wb_data_q <= '0;
`endif
    end else begin
      addr_q <= addr_d;
      way_q  <= way_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
`ifdef REFILL_WRITEBACK_EN
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: transaction scoreboard plus directed misses.
// Writeback scenarios are exercised when REFILL_WRITEBACK_EN is defined.
module tb_cache_refill_unit;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_valid = 1'b0;
  logic         miss_ready;
  logic [31:0]  miss_addr = '0;
  logic [2:0]   miss_way = '0;
  logic         miss_wb = 1'b0;
  logic [31:0]  miss_wb_addr = '0;
  logic [127:0] miss_wb_data = '0;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_wdata;
  logic         mem_wvalid;
  logic         mem_wready = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         mem_rvalid = 1'b0;
  logic         fill_valid;
  logic         fill_ready = 1'b0;
  logic [31:0]  fill_addr;
  logic [2:0]   fill_way;
  logic [127:0] fill_data;
  logic         busy;

  cache_refill_unit dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_way(miss_way), .miss_wb(miss_wb), .miss_wb_addr(miss_wb_addr),
    .miss_wb_data(miss_wb_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_way(fill_way), .fill_data(fill_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder knobs
  int          req_stall = 0;
  bit          wr_toggle = 1'b0;
  bit          rd_gap = 1'b0;
  bit          stray_en = 1'b0;
  logic [31:0] rd_beats [4];
  int          timing_exp = 0;

  // Memory model: request stalls, optional wready toggling, read burst with optional gaps.
  initial begin
    int  stall_left;
    bit  pend;
    bit  in_burst;
    bit  gap_skip;
    bit  tog;
    int  bidx;
    stall_left = 0; pend = 1'b0; in_burst = 1'b0; gap_skip = 1'b0; tog = 1'b0; bidx = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
        pend = 1'b0; in_burst = 1'b0; stall_left = req_stall;
      end else begin
        if (pend) begin in_burst = 1'b1; bidx = 0; gap_skip = 1'b0; end
        pend = 1'b0;
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            mem_req_ready = 1'b0; stall_left--;
          end else begin
            mem_req_ready = 1'b1; pend = !mem_req_write;
          end
        end else begin
          mem_req_ready = 1'b0; stall_left = req_stall;
        end
        tog = ~tog;
        mem_wready = wr_toggle ? tog : 1'b1;
        if (in_burst) begin
          if (rd_gap && gap_skip) begin
            mem_rvalid = 1'b0; gap_skip = 1'b0;
          end else begin
            mem_rvalid = 1'b1; mem_rdata = rd_beats[bidx[1:0]];
            bidx++; gap_skip = 1'b1;
            if (bidx == 4) in_burst = 1'b0;
          end
        end else begin
          mem_rvalid = stray_en & tog;
          mem_rdata  = 32'hBAD0_0000 + 32'(bidx);
        end
      end
    end
  end

  // Scoreboard model
  typedef struct packed { logic wr; logic [31:0] addr; } req_t;
  req_t         exp_req [$];
  logic [31:0]  exp_wbeat [$];
  bit           outstanding = 1'b0;
  bit           rd_open = 1'b0;
  bit           fill_pend = 1'b0;
  int           nbeats = 0;
  int           cyc = 0;
  logic [127:0] model_line = '0;
  logic [31:0]  exp_faddr = '0;
  logic [2:0]   exp_fway = '0;
  logic [127:0] last_fill_data = '0;
  logic [31:0]  last_fill_addr = '0;
  logic [2:0]   last_fill_way = '0;
  logic [31:0]  last_rd_addr = '0;
`ifdef REFILL_WRITEBACK_EN
  logic [31:0]  last_wr_addr = '0;
  logic [31:0]  first_wbeat = '0;
  bit           wb_first = 1'b1;
`else
  bit           saw_write = 1'b0;
`endif

  initial begin
    bit prev_rv, prev_rr, prev_wv, prev_wr, prev_fv, prev_fr;
    logic [32:0]  prev_req;
    logic [31:0]  prev_wd, prev_fa;
    logic [2:0]   prev_fw;
    logic [127:0] prev_fd;
    req_t         r;
    logic [31:0]  e;
    prev_rv = 0; prev_rr = 0; prev_wv = 0; prev_wr = 0; prev_fv = 0; prev_fr = 0;
    prev_req = '0; prev_wd = '0; prev_fa = '0; prev_fw = '0; prev_fd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl", 128'({miss_ready, busy, mem_req_valid, mem_req_write, mem_wvalid, fill_valid}), 128'(0));
        chk("reset_bus", 128'({mem_req_addr, mem_wdata, fill_addr, fill_way}), 128'(0));
        chk("reset_fill_data", fill_data, 128'(0));
        exp_req.delete(); exp_wbeat.delete();
        outstanding = 0; rd_open = 0; fill_pend = 0; nbeats = 0;
        prev_rv = 0; prev_wv = 0; prev_fv = 0;
      end else begin
        if (outstanding) cyc++;
        chk("miss_ready", 128'(miss_ready), 128'(!outstanding));
        chk("busy", 128'(busy), 128'(outstanding));
        chk("ready_fill_excl", 128'(miss_ready & fill_valid), 128'(0));
`ifndef REFILL_WRITEBACK_EN
        chk("no_write", 128'({mem_req_write, mem_wvalid}), 128'(0));
        if (mem_req_write || mem_wvalid) saw_write = 1'b1;
`endif
        if (prev_rv && !prev_rr)
          chk("req_hold", 128'({mem_req_valid, mem_req_write, mem_req_addr}), 128'({1'b1, prev_req}));
        if (prev_wv && !prev_wr)
          chk("wbeat_hold", 128'({mem_wvalid, mem_wdata}), 128'({1'b1, prev_wd}));
        if (prev_fv && !prev_fr) begin
          chk("fill_hold", 128'({fill_valid, fill_addr, fill_way}), 128'({1'b1, prev_fa, prev_fw}));
          chk("fill_data_hold", fill_data, prev_fd);
        end
        if (timing_exp != 0 && fill_valid && !prev_fv)
          chk("fill_cycle", 128'(cyc), 128'(timing_exp));
        if (mem_rvalid && rd_open) begin
          model_line[nbeats*32 +: 32] = mem_rdata;
          nbeats++;
          if (nbeats == 4) begin rd_open = 0; fill_pend = 1; end
        end
        if (mem_wvalid && mem_wready) begin
          if (exp_wbeat.size() == 0) chk("stray_wbeat", 128'(mem_wvalid), 128'(0));
          else begin
            e = exp_wbeat.pop_front();
            chk("wbeat", 128'(mem_wdata), 128'(e));
`ifdef REFILL_WRITEBACK_EN
            if (wb_first) begin first_wbeat = mem_wdata; wb_first = 0; end
`endif
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          if (exp_req.size() == 0) chk("stray_req", 128'(mem_req_valid), 128'(0));
          else begin
            r = exp_req.pop_front();
            chk("req_write", 128'(mem_req_write), 128'(r.wr));
            chk("req_addr", 128'(mem_req_addr), 128'(r.addr));
            if (!r.wr) begin
              chk("rd_after_wb", 128'(exp_wbeat.size()), 128'(0));
              rd_open = 1; nbeats = 0; last_rd_addr = mem_req_addr;
            end
`ifdef REFILL_WRITEBACK_EN
            else last_wr_addr = mem_req_addr;
`endif
          end
        end
        if (fill_valid && fill_ready) begin
          chk("fill_pending", 128'({fill_valid, fill_pend}), 128'(2'b11));
          chk("fill_addr", 128'(fill_addr), 128'(exp_faddr));
          chk("fill_way", 128'(fill_way), 128'(exp_fway));
          chk("fill_data", fill_data, model_line);
          last_fill_data = fill_data; last_fill_addr = fill_addr; last_fill_way = fill_way;
          fill_pend = 0; outstanding = 0;
        end
        if (miss_valid && miss_ready) begin
          outstanding = 1; cyc = 0; model_line = '0;
`ifdef REFILL_WRITEBACK_EN
          if (miss_wb) begin
            exp_req.push_back('{wr: 1'b1, addr: miss_wb_addr & 32'hFFFF_FFF0});
            for (int k = 0; k < 4; k++) exp_wbeat.push_back(miss_wb_data[k*32 +: 32]);
            wb_first = 1;
          end
`endif
          exp_req.push_back('{wr: 1'b0, addr: miss_addr & 32'hFFFF_FFF0});
          exp_faddr = miss_addr & 32'hFFFF_FFF0;
          exp_fway  = miss_way;
        end
        prev_rv = mem_req_valid; prev_rr = mem_req_ready;
        prev_req = {mem_req_write, mem_req_addr};
        prev_wv = mem_wvalid; prev_wr = mem_wready; prev_wd = mem_wdata;
        prev_fv = fill_valid; prev_fr = fill_ready;
        prev_fa = fill_addr; prev_fw = fill_way; prev_fd = fill_data;
      end
    end
  end

  task automatic do_miss(input logic [31:0] a, input logic [2:0] w, input logic wb,
                         input logic [31:0] wa, input logic [127:0] wd);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_addr = a; miss_way = w;
    miss_wb = wb; miss_wb_addr = wa; miss_wb_data = wd;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (miss_ready) begin ok = 1'b1; break; end
    end
    chk("miss_accept_timeout", 128'(ok), 128'(1));
    @(posedge clk); #1;
    miss_valid = 1'b0;
    $display("miss addr=%08h way=%0d wb=%0d accepted", a, w, wb);
  endtask

  task automatic wait_fill(input int stall);
    bit ok;
    int st;
    ok = 1'b0; st = stall;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (fill_valid) begin
        if (st > 0) st--;
        else begin fill_ready = 1'b1; ok = 1'b1; break; end
      end
    end
    chk("fill_timeout", 128'(ok), 128'(1));
    @(posedge clk); #1;
    fill_ready = 1'b0;
    $display("fill addr=%08h way=%0d data=%032h", last_fill_addr, last_fill_way, last_fill_data);
  endtask

  initial begin
    rd_beats = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(miss_ready), 128'(1));

    // Clean miss, memory always ready
    timing_exp = 6;
    do_miss(32'h0000_1234, 3'd3, 1'b0, 32'h0, 128'h0);
    wait_fill(0);
    timing_exp = 0;
    chk("lit_clean_rd_addr", 128'(last_rd_addr), 128'(32'h0000_1230));
    chk("lit_clean_addr", 128'(last_fill_addr), 128'(32'h0000_1230));
    chk("lit_clean_way", 128'(last_fill_way), 128'(3'd3));
    chk("lit_clean_data", last_fill_data, 128'h44444444_33333333_22222222_11111111);

    // Dirty victim (ignored when the writeback path is absent)
    rd_beats = '{32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
`ifdef REFILL_WRITEBACK_EN
    timing_exp = 11;
`else
    timing_exp = 6;
`endif
    do_miss(32'h0000_4567, 3'd5, 1'b1, 32'h0000_8000,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    wait_fill(0);
    timing_exp = 0;
`ifdef REFILL_WRITEBACK_EN
    chk("lit_wb_addr", 128'(last_wr_addr), 128'(32'h0000_8000));
    chk("lit_wb_first_beat", 128'(first_wbeat), 128'(32'hAAAA_AAAA));
`else
    chk("lit_no_write_burst", 128'(saw_write), 128'(0));
`endif
    chk("lit_dirty_rd_addr", 128'(last_rd_addr), 128'(32'h0000_4560));
    chk("lit_dirty_data", last_fill_data, 128'h88888888_77777777_66666666_55555555);

    // Backpressure on request, write beats and fill
    req_stall = 3; wr_toggle = 1'b1;
    rd_beats = '{32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
    do_miss(32'h0000_ABCD, 3'd7, 1'b1, 32'h0000_9010,
            128'h0F0E0D0C_0B0A0908_07060504_03020100);
    wait_fill(2);
    chk("lit_bp_way", 128'(last_fill_way), 128'(3'd7));
    chk("lit_bp_data", last_fill_data, 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999);

    // Stray rvalid in IDLE/RD_REQ, gapped read beats
    req_stall = 2; wr_toggle = 1'b0; stray_en = 1'b1; rd_gap = 1'b1;
    rd_beats = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    repeat (4) @(posedge clk);
    do_miss(32'h0000_0F00, 3'd1, 1'b0, 32'h0, 128'h0);
    wait_fill(0);
    chk("lit_gap_data", last_fill_data, 128'h04040404_03030303_02020202_01010101);
    stray_en = 1'b0; rd_gap = 1'b0; req_stall = 0;

    // Reset during the second read beat
    rd_beats = '{32'hEEEE_0000, 32'hEEEE_0001, 32'hEEEE_0002, 32'hEEEE_0003};
    do_miss(32'h0000_2000, 3'd2, 1'b0, 32'h0, 128'h0);
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    $display("reset applied mid-burst");
    @(negedge clk);
    chk("busy_after_mid_rst", 128'(busy), 128'(0));
    repeat (5) @(posedge clk);

    // Clean miss after reset
    rd_beats = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    timing_exp = 6;
    do_miss(32'h3000_0017, 3'd6, 1'b0, 32'h0, 128'h0);
    wait_fill(0);
    timing_exp = 0;
    chk("lit_post_rst_addr", 128'(last_fill_addr), 128'(32'h3000_0010));
    chk("lit_post_rst_data", last_fill_data, 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
